frame_mem_arbiter: RTL and testbench
====================================

Name: frame_mem_arbiter

Overview:
- Shares one single-port synchronous frame BRAM between three requesters: camera pixel writer, filter engine (read/write), and host readout (read-only).
- The camera has fixed top priority. The filter engine and host share the remaining slots round-robin.
- A starvation guard pre-empts the camera for one cycle when a low-priority requester has waited too long.
- Sits between the sequencing controller's datapath blocks and the frame BRAM.

Parameters:
- ADDR_W, 16, frame memory address width
- DATA_W, 8, pixel width (grayscale)
- MAX_WAIT, 15, consecutive blocked cycles before a starvation grant; legal range 1..255

Ports:
- clk  in  1  clock
- erst  in  1  synchronous, active-high reset
- cam_req  in  1  camera write request
- cam_addr  in  ADDR_W  camera write address
- cam_wdata  in  DATA_W  camera write data
- cam_gnt  out  1  camera access accepted this cycle
- flt_req  in  1  filter request
- flt_we  in  1  filter request is a write (1) or read (0)
- flt_addr  in  ADDR_W  filter address
- flt_wdata  in  DATA_W  filter write data
- flt_gnt  out  1  filter access accepted this cycle
- flt_rvalid  out  1  filter read data valid
- flt_rdata  out  DATA_W  filter read data
- host_req  in  1  host read request
- host_addr  in  ADDR_W  host read address
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, one cycle after a read access
- busy  out  1  any req high this cycle

Behaviour:
- Transfer rule: req and gnt both high in the same cycle means the access is performed that cycle.
  - gnt is combinational from req and registered arbiter state.
  - A requester holds req, addr and data stable until granted.
  - At most one gnt is high per cycle.
- Memory drive: mem_* is driven combinationally from the granted requester.
  - With no grant: mem_en=0, mem_we=0, mem_addr and mem_wdata hold 0.
  - Camera grant forces mem_we=1. Host grant forces mem_we=0. Filter grant drives mem_we=flt_we.
- Priority each cycle:
  1. Starved requester (flag set, see below). If both are starved, the round-robin pointer picks.
  2. Camera.
  3. Filter or host, by round-robin pointer.
- Round-robin pointer (1 bit, reset = FLT):
  - Updates only on a filter or host grant, pointing to the other requester.
  - When only one of the two requests, that one is granted and the pointer still flips.
- Starvation counters: one per filter and host, 8-bit.
  - Increments when req=1 and gnt=0.
  - Clears on gnt or when req=0.
  - Saturates at MAX_WAIT. The starve flag is count==MAX_WAIT.
  - A starved grant takes one cycle. The camera sees cam_gnt=0 that cycle and must hold its request.
- Read return: one-cycle latency.
  - flt_rvalid is registered and set the cycle after a filter read grant (flt_we=0). host_rvalid likewise for a host grant.
  - rdata = mem_rdata passthrough, qualified by rvalid.
  - Writes never raise rvalid.
- Back-to-back: a new access may be granted every cycle, including a read immediately after a write to the same address. The BRAM is read-first; arbiter ordering is preserved as grant order.
- Reset (erst=1 at posedge):
  - rvalid regs=0, counters=0, pointer=FLT.
  - While erst=1, all gnt=0, mem_en=0 and mem_we=0, regardless of req.
  - A read granted in the cycle before reset asserts produces no rvalid afterwards: rvalid is cleared by reset.
- busy = cam_req | flt_req | host_req (combinational); 0 during reset.

Decomposition:
- Shared package frame_mem_pkg holds:
  - Requester ID constants: REQ_NONE=2'd0, REQ_CAM=2'd1, REQ_FLT=2'd2, REQ_HOST=2'd3.
  - Default ADDR_W/DATA_W.
- One sub-module, starve_counter (params MAX_WAIT; ports clk, erst, req, gnt, starved), instantiated twice.
- Grant decode and mem mux stay in the top.

Test Plan:
- Camera only: cam_req held 4 cycles, addr 0x0010..0x0013, data 0xA0..0xA3 -> cam_gnt=1 each cycle, mem_we=1, mem_addr/mem_wdata match, no rvalid.
- Filter and host contend, camera idle:
  - Both req high 4 cycles after reset -> grants FLT, HOST, FLT, HOST.
  - flt_rvalid/host_rvalid each follow their grant by one cycle, with rdata = model memory contents.
- Starvation: cam_req held continuously, flt_req held from cycle 0 with MAX_WAIT=15.
  - flt_gnt=0 for cycles 0..14, flt_gnt=1 and cam_gnt=0 at cycle 15.
  - Counter clears and the camera regains the grant at cycle 16.
- Both starved under camera load: flt and host req from the same cycle -> after 15 cycles, filter is granted (pointer=FLT), host on the next cycle.
- Write-then-read same address: filter write 0x5A to 0x0100, then filter read 0x0100 next cycle -> flt_rvalid one cycle after the read grant, flt_rdata=0x5A.
- Reset mid-operation: host read granted at cycle N, erst=1 at cycle N+1 -> host_rvalid=0, all gnt=0 and mem_en=0 while erst=1; after release, pointer=FLT and counters restart from 0.

Source files
------------

// File: rtl/frame_mem_pkg.sv
// Shared definitions for the frame memory arbiter: requester IDs,
// default bus widths and the round-robin pointer encoding.
package frame_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_CAM  = 2'd1;
    localparam logic [1:0] REQ_FLT  = 2'd2;
    localparam logic [1:0] REQ_HOST = 2'd3;

    typedef enum logic {
        RR_FLT  = 1'b0,
        RR_HOST = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive blocked cycles of one low-priority requester and
// flags it once the wait limit is reached.
module starve_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic erst,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (erst) begin
            r_cnt <= '0;
        end else if (!req || gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign starved = (r_cnt == LIMIT);

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port frame BRAM arbiter: camera first, filter/host round-robin,
// with a one-cycle starvation pre-emption of the camera.
module frame_mem_arbiter
    import frame_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              erst,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_gnt,
    input  logic              flt_req,
    input  logic              flt_we,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [DATA_W-1:0] flt_wdata,
    output logic              flt_gnt,
    output logic              flt_rvalid,
    output logic [DATA_W-1:0] flt_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    rr_ptr_e    r_ptr;
    logic       r_flt_rvalid;
    logic       r_host_rvalid;

    logic       w_flt_starved;
    logic       w_host_starved;
    logic       w_flt_hungry;
    logic       w_host_hungry;
    logic [1:0] w_rr_pick;
    logic [1:0] w_sel;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_flt_starve (
        .clk     (clk),
        .erst    (erst),
        .req     (flt_req),
        .gnt     (flt_gnt),
        .starved (w_flt_starved)
    );

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_host_starve (
        .clk     (clk),
        .erst    (erst),
        .req     (host_req),
        .gnt     (host_gnt),
        .starved (w_host_starved)
    );

    // A saturated count only matters while the requester is still asking.
    assign w_flt_hungry  = w_flt_starved & flt_req;
    assign w_host_hungry = w_host_starved & host_req;
    assign w_rr_pick     = (r_ptr == RR_HOST) ? REQ_HOST : REQ_FLT;

    always_comb begin
        w_sel = REQ_NONE;
        if (erst) begin
            w_sel = REQ_NONE;
        end else if (w_flt_hungry && w_host_hungry) begin
            w_sel = w_rr_pick;
        end else if (w_flt_hungry) begin
            w_sel = REQ_FLT;
        end else if (w_host_hungry) begin
            w_sel = REQ_HOST;
        end else if (cam_req) begin
            w_sel = REQ_CAM;
        end else if (flt_req && host_req) begin
            w_sel = w_rr_pick;
        end else if (flt_req) begin
            w_sel = REQ_FLT;
        end else if (host_req) begin
            w_sel = REQ_HOST;
        end
    end

    assign cam_gnt  = (w_sel == REQ_CAM);
    assign flt_gnt  = (w_sel == REQ_FLT);
    assign host_gnt = (w_sel == REQ_HOST);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (w_sel)
            REQ_CAM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cam_addr;
                mem_wdata = cam_wdata;
            end
            REQ_FLT: begin
                mem_en    = 1'b1;
                mem_we    = flt_we;
                mem_addr  = flt_addr;
                mem_wdata = flt_wdata;
            end
            REQ_HOST: begin
                mem_en    = 1'b1;
                mem_addr  = host_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (erst) begin
            r_ptr <= RR_FLT;
        end else if (flt_gnt) begin
            r_ptr <= RR_HOST;
        end else if (host_gnt) begin
            r_ptr <= RR_FLT;
        end
    end

    always_ff @(posedge clk) begin
        if (erst) begin
            r_flt_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_flt_rvalid  <= flt_gnt & ~flt_we;
            r_host_rvalid <= host_gnt;
        end
    end

    // Masking with erst drops a read return that lands in a reset cycle.
    assign flt_rvalid  = r_flt_rvalid & ~erst;
    assign host_rvalid = r_host_rvalid & ~erst;
    assign flt_rdata   = flt_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

    assign busy = (cam_req | flt_req | host_req) & ~erst;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Randomized and directed checks of frame_mem_arbiter against a
// cycle-level reference model with its own shadow frame memory.
module tb_frame_mem_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int MAXW   = 15;
    localparam int G_NONE = 0;
    localparam int G_CAM  = 1;
    localparam int G_FLT  = 2;
    localparam int G_HOST = 3;

    logic          clk = 1'b0;
    logic          erst = 1'b1;
    logic          cam_req = 1'b0;
    logic [AW-1:0] cam_addr = '0;
    logic [DW-1:0] cam_wdata = '0;
    logic          cam_gnt;
    logic          flt_req = 1'b0;
    logic          flt_we = 1'b0;
    logic [AW-1:0] flt_addr = '0;
    logic [DW-1:0] flt_wdata = '0;
    logic          flt_gnt;
    logic          flt_rvalid;
    logic [DW-1:0] flt_rdata;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    frame_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .erst        (erst),
        .cam_req     (cam_req),
        .cam_addr    (cam_addr),
        .cam_wdata   (cam_wdata),
        .cam_gnt     (cam_gnt),
        .flt_req     (flt_req),
        .flt_we      (flt_we),
        .flt_addr    (flt_addr),
        .flt_wdata   (flt_wdata),
        .flt_gnt     (flt_gnt),
        .flt_rvalid  (flt_rvalid),
        .flt_rdata   (flt_rdata),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Read-first single-port BRAM seen by the DUT.
    logic [DW-1:0] bram [0:65535];
    initial begin
        logic [DW-1:0] rd;
        for (int i = 0; i < 65536; i++) bram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                rd = bram[mem_addr];
                if (mem_we) bram[mem_addr] = mem_wdata;
                mem_rdata <= rd;
            end
        end
    end

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] ref_mem [0:65535];
    int            wf = 0;
    int            wh = 0;
    bit            ptr_host = 1'b0;
    bit            p_frv = 1'b0;
    bit            p_hrv = 1'b0;
    logic [DW-1:0] p_frd = '0;
    logic [DW-1:0] p_hrd = '0;
    int            last_g = G_NONE;
    bit            obs_frv;
    bit            obs_hrv;
    logic [DW-1:0] obs_frd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int exp_grant();
        bit fs;
        bit hs;
        int rr;
        fs = flt_req && (wf == MAXW);
        hs = host_req && (wh == MAXW);
        rr = ptr_host ? G_HOST : G_FLT;
        if (erst) return G_NONE;
        if (fs && hs) return rr;
        if (fs) return G_FLT;
        if (hs) return G_HOST;
        if (cam_req) return G_CAM;
        if (flt_req && host_req) return rr;
        if (flt_req) return G_FLT;
        if (host_req) return G_HOST;
        return G_NONE;
    endfunction

    // One clock: check all outputs at negedge, advance model, step past posedge.
    task automatic cycle();
        int            g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        bit            any;
        @(negedge clk);
        g = exp_grant();
        chk("cam_gnt", 32'(cam_gnt), 32'(g == G_CAM));
        chk("flt_gnt", 32'(flt_gnt), 32'(g == G_FLT));
        chk("host_gnt", 32'(host_gnt), 32'(g == G_HOST));
        chk("mem_en", 32'(mem_en), 32'(g != G_NONE));
        chk("mem_we", 32'(mem_we),
            32'(g == G_CAM || (g == G_FLT && flt_we)));
        case (g)
            G_CAM:   ea = cam_addr;
            G_FLT:   ea = flt_addr;
            G_HOST:  ea = host_addr;
            default: ea = '0;
        endcase
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (g != G_HOST) begin
            ew = (g == G_CAM) ? cam_wdata : (g == G_FLT) ? flt_wdata : 8'h00;
            chk("mem_wdata", 32'(mem_wdata), 32'(ew));
        end
        any = !erst && (cam_req || flt_req || host_req);
        chk("busy", 32'(busy), 32'(any));
        chk("flt_rvalid", 32'(flt_rvalid), 32'(p_frv && !erst));
        if (p_frv && !erst) chk("flt_rdata", 32'(flt_rdata), 32'(p_frd));
        chk("host_rvalid", 32'(host_rvalid), 32'(p_hrv && !erst));
        if (p_hrv && !erst) chk("host_rdata", 32'(host_rdata), 32'(p_hrd));
        obs_frv = flt_rvalid;
        obs_frd = flt_rdata;
        obs_hrv = host_rvalid;
        last_g  = g;
        p_frv   = 1'b0;
        p_hrv   = 1'b0;
        if (erst) begin
            wf = 0;
            wh = 0;
            ptr_host = 1'b0;
        end else begin
            case (g)
                G_CAM: ref_mem[cam_addr] = cam_wdata;
                G_FLT: begin
                    if (flt_we) ref_mem[flt_addr] = flt_wdata;
                    else begin
                        p_frv = 1'b1;
                        p_frd = ref_mem[flt_addr];
                    end
                end
                G_HOST: begin
                    p_hrv = 1'b1;
                    p_hrd = ref_mem[host_addr];
                end
                default: ;
            endcase
            wf = (flt_req && g != G_FLT) ? ((wf < MAXW) ? wf + 1 : MAXW) : 0;
            wh = (host_req && g != G_HOST) ? ((wh < MAXW) ? wh + 1 : MAXW) : 0;
            if (g == G_FLT) ptr_host = 1'b1;
            else if (g == G_HOST) ptr_host = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        erst = 1'b1;
        cam_req = 1'b0;
        flt_req = 1'b0;
        host_req = 1'b0;
        cycle();
        cycle();
        erst = 1'b0;
    endtask

    initial begin
        int n;
        int hit;
        int hf;
        int hh;
        int seq [4];
        int pct [3];
        pct[0] = 20;
        pct[1] = 60;
        pct[2] = 90;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        #1;

        // Camera alone: four back-to-back writes.
        do_reset();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cam_req = 1'b1;
            cam_addr = 16'h0010 + 16'(i);
            cam_wdata = 8'hA0 + 8'(i);
            cycle();
            if (last_g == G_CAM) n++;
        end
        cam_req = 1'b0;
        chk("cam_only_gnts", 32'(n), 32'd4);
        cycle();

        // Filter and host reading in contention alternate from FLT.
        do_reset();
        flt_req = 1'b1;
        flt_we = 1'b0;
        flt_addr = 16'h0010;
        host_req = 1'b1;
        host_addr = 16'h0012;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = last_g;
            if (last_g == G_FLT) flt_addr = flt_addr + 16'd1;
            if (last_g == G_HOST) host_addr = host_addr + 16'd1;
        end
        flt_req = 1'b0;
        host_req = 1'b0;
        for (int i = 0; i < 4; i++)
            chk("rr_seq", 32'(seq[i]), 32'((i % 2 == 0) ? G_FLT : G_HOST));
        cycle();
        cycle();

        // Filter starved behind a continuous camera stream.
        do_reset();
        cam_req = 1'b1;
        cam_addr = 16'h0020;
        cam_wdata = 8'h11;
        flt_req = 1'b1;
        flt_we = 1'b0;
        flt_addr = 16'h0021;
        hit = -1;
        for (int i = 0; i < 40 && hit < 0; i++) begin
            cycle();
            if (last_g == G_FLT) hit = i;
        end
        chk("starve_cycle", 32'(hit), 32'd15);
        flt_req = 1'b0;
        cycle();
        chk("cam_regain", 32'(last_g), 32'(G_CAM));
        cam_req = 1'b0;
        cycle();

        // Both starved together: filter first, host next cycle.
        do_reset();
        cam_req = 1'b1;
        flt_req = 1'b1;
        flt_we = 1'b1;
        flt_addr = 16'h0030;
        flt_wdata = 8'h77;
        host_req = 1'b1;
        host_addr = 16'h0030;
        hf = -1;
        hh = -1;
        for (int i = 0; i < 40 && (hf < 0 || hh < 0); i++) begin
            cycle();
            if (last_g == G_FLT) begin
                hf = i;
                flt_req = 1'b0;
            end
            if (last_g == G_HOST) begin
                hh = i;
                host_req = 1'b0;
            end
        end
        chk("both_starve_flt", 32'(hf), 32'd15);
        chk("both_starve_host", 32'(hh), 32'd16);
        cam_req = 1'b0;
        cycle();
        cycle();

        // Write then read of the same address.
        do_reset();
        flt_req = 1'b1;
        flt_we = 1'b1;
        flt_addr = 16'h0100;
        flt_wdata = 8'h5A;
        cycle();
        chk("wr_gnt", 32'(last_g), 32'(G_FLT));
        flt_we = 1'b0;
        cycle();
        chk("rd_gnt", 32'(last_g), 32'(G_FLT));
        flt_req = 1'b0;
        cycle();
        chk("wr_rd_valid", 32'(obs_frv), 32'd1);
        chk("wr_rd_data", 32'(obs_frd), 32'h5A);

        // Reset right after a host read grant.
        do_reset();
        flt_req = 1'b1;
        flt_we = 1'b1;
        flt_addr = 16'h0040;
        flt_wdata = 8'h99;
        cycle();
        flt_we = 1'b0;
        flt_addr = 16'h0041;
        host_req = 1'b1;
        host_addr = 16'h0040;
        cycle();
        chk("rst_host_gnt", 32'(last_g), 32'(G_HOST));
        host_req = 1'b0;
        cam_req = 1'b1;
        erst = 1'b1;
        cycle();
        chk("rst_hrv", 32'(obs_hrv), 32'd0);
        chk("rst_no_gnt", 32'(last_g), 32'(G_NONE));
        cycle();
        erst = 1'b0;
        hit = -1;
        for (int i = 0; i < 40 && hit < 0; i++) begin
            cycle();
            if (last_g == G_FLT) hit = i;
        end
        chk("starve_after_rst", 32'(hit), 32'd15);
        flt_req = 1'b0;
        cam_req = 1'b0;
        cycle();

        // Randomized traffic at several camera loads with sporadic resets.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 600; c++) begin
                cycle();
                erst = ($urandom_range(0, 199) == 0);
                if (last_g == G_CAM) cam_req = 1'b0;
                if (last_g == G_FLT) flt_req = 1'b0;
                if (last_g == G_HOST) host_req = 1'b0;
                if (!cam_req && $urandom_range(0, 99) < pct[ph]) begin
                    cam_req = 1'b1;
                    cam_addr = 16'($urandom_range(0, 15));
                    cam_wdata = 8'($urandom);
                end
                if (!flt_req && $urandom_range(0, 99) < 50) begin
                    flt_req = 1'b1;
                    flt_we = 1'($urandom_range(0, 1));
                    flt_addr = 16'($urandom_range(0, 15));
                    flt_wdata = 8'($urandom);
                end
                if (!host_req && $urandom_range(0, 99) < 40) begin
                    host_req = 1'b1;
                    host_addr = 16'($urandom_range(0, 15));
                end
            end
        end
        erst = 1'b0;
        cam_req = 1'b0;
        flt_req = 1'b0;
        host_req = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
